// File: rtl/cond_pkg.sv
// Shared condition-code definitions: condition enum, NZCV bit positions and
// the condition evaluation function used by the conditional-execution stage.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_pass(cond_e c, logic [3:0] flags);
    logic n, z, cf, v, p;
    n  = flags[FLAG_N];
    z  = flags[FLAG_Z];
    cf = flags[FLAG_C];
    v  = flags[FLAG_V];
    p  = 1'b1;
    case (c)
      EQ: p = z;
      NE: p = ~z;
      CS: p = cf;
      CC: p = ~cf;
      MI: p = n;
      PL: p = ~n;
      VS: p = v;
      VC: p = ~v;
      HI: p = cf & ~z;
      LS: p = ~cf | z;
      GE: p = (n == v);
      LT: p = (n != v);
      GT: p = ~z & (n == v);
      LE: p = z | (n != v);
      AL: p = 1'b1;
      NV: p = 1'b1;  // NV executes unconditionally rather than acting as never
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: condition field against NZCV flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  assign pass_o = cond_pass(cond_e'(cond_i), flags_i);

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution pipeline stage: owns the NZCV register, gates write
// enables by the decoded condition and counts squashed instructions.
module cond_unit
  import cond_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_write,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             reg_write_in,
  input  logic             mem_write_in,
  input  logic             pc_src_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_q,
  output logic             reg_write,
  output logic             mem_write,
  output logic             pc_src,
  output logic             cond_ex,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] squash_cnt
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_write_q, mem_write_d;
  logic             pc_src_q, pc_src_d;
  logic             cond_ex_q, cond_ex_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic             pass;
  logic             accept;

  // Decode against the architectural flags, never the incoming alu_flags.
  cond_check u_check (
    .cond_i  (cond),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;
    pc_src_d    = pc_src_q;
    cond_ex_d   = cond_ex_q;
    flags_d     = flags_q;
    squash_d    = squash_q;
    if (accept) begin
      valid_d     = 1'b1;
      data_d      = alu_result;
      cond_ex_d   = pass;
      reg_write_d = reg_write_in & pass;
      mem_write_d = mem_write_in & pass;
      pc_src_d    = pc_src_in & pass;
      if (pass) begin
        if (flag_write[1]) begin
          flags_d[FLAG_N] = alu_flags[FLAG_N];
          flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (flag_write[0]) begin
          flags_d[FLAG_C] = alu_flags[FLAG_C];
          flags_d[FLAG_V] = alu_flags[FLAG_V];
        end
      end else if (squash_q != {CNT_W{1'b1}}) begin
        squash_d = squash_q + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      pc_src_q    <= 1'b0;
      cond_ex_q   <= 1'b0;
      flags_q     <= 4'b0000;
      squash_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      pc_src_q    <= pc_src_d;
      cond_ex_q   <= cond_ex_d;
      flags_q     <= flags_d;
      squash_q    <= squash_d;
    end
  end

  assign out_valid  = valid_q;
  assign result_q   = data_q;
  assign reg_write  = reg_write_q;
  assign mem_write  = mem_write_q;
  assign pc_src     = pc_src_q;
  assign cond_ex    = cond_ex_q;
  assign flags      = flags_q;
  assign squash_cnt = squash_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed scoreboard bench for cond_unit: expected outputs are queued on
// accept and compared when the stage presents them.
module tb_cond_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cond;
  logic [3:0]       alu_flags;
  logic [1:0]       flag_write;
  logic [WIDTH-1:0] alu_result;
  logic             reg_write_in, mem_write_in, pc_src_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_q;
  logic             reg_write, mem_write, pc_src, cond_ex;
  logic [3:0]       flags;
  logic [CNT_W-1:0] squash_cnt;

  always #5 clk = ~clk;

  cond_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .alu_flags(alu_flags), .flag_write(flag_write),
    .alu_result(alu_result),
    .reg_write_in(reg_write_in), .mem_write_in(mem_write_in), .pc_src_in(pc_src_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_q(result_q),
    .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src),
    .cond_ex(cond_ex), .flags(flags), .squash_cnt(squash_cnt)
  );

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             rw, mw, ps, cx;
  } exp_t;

  exp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic             m_ov;
  logic [3:0]       m_flags;
  logic [CNT_W-1:0] m_cnt;

  // Reference: even codes test a base predicate, odd codes invert it; 14/15 always pass.
  function automatic logic ref_pass(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = n ~^ v;
      3'd6:    base = ~z & (n ~^ v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, compare the presented output before the edge,
  // update the model across the edge, then check architectural state.
  task automatic step(input logic iv, input logic [3:0] c, input logic [3:0] af,
                      input logic [1:0] fw, input logic rw, input logic mw,
                      input logic ps, input logic ordy);
    logic acc, p;
    exp_t e;
    in_valid     = iv;
    cond         = c;
    alu_flags    = af;
    flag_write   = fw;
    alu_result   = $urandom();
    reg_write_in = rw;
    mem_write_in = mw;
    pc_src_in    = ps;
    out_ready    = ordy;
    @(negedge clk);
    check("in_ready", {31'b0, in_ready}, {31'b0, ~m_ov | ordy});
    if (m_ov) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb[0];
        check("result_q", result_q, e.res);
        check("enables", {28'b0, reg_write, mem_write, pc_src, cond_ex},
              {28'b0, e.rw, e.mw, e.ps, e.cx});
        if (ordy) void'(sb.pop_front());
      end
    end
    acc = iv & (~m_ov | ordy);
    if (acc) begin
      p = ref_pass(c, m_flags);
      e.res = alu_result;
      e.rw  = rw & p;
      e.mw  = mw & p;
      e.ps  = ps & p;
      e.cx  = p;
      sb.push_back(e);
      if (p) begin
        if (fw[1]) m_flags[3:2] = af[3:2];
        if (fw[0]) m_flags[1:0] = af[1:0];
      end else if (m_cnt != {CNT_W{1'b1}}) begin
        m_cnt = m_cnt + 1'b1;
      end
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    check("flags", {28'b0, flags}, {28'b0, m_flags});
    check("squash_cnt", {{(32-CNT_W){1'b0}}, squash_cnt}, {{(32-CNT_W){1'b0}}, m_cnt});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_result"}, result_q, 32'd0);
    check({tag, "_enables"}, {28'b0, reg_write, mem_write, pc_src, cond_ex}, 32'd0);
    check({tag, "_flags"}, {28'b0, flags}, 32'd0);
    check({tag, "_cnt"}, {{(32-CNT_W){1'b0}}, squash_cnt}, 32'd0);
  endtask

  task automatic model_reset();
    m_ov    = 1'b0;
    m_flags = 4'b0000;
    m_cnt   = '0;
    sb.delete();
  endtask

  initial begin
    in_valid = 0; cond = 0; alu_flags = 0; flag_write = 0; alu_result = 0;
    reg_write_in = 0; mem_write_in = 0; pc_src_in = 0; out_ready = 1;
    model_reset();
    #1 reset = 1'b1;
    #10 reset = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset");

    // First post-reset EQ fails; NE would pass.
    step(1, 4'h0, 4'b0100, 2'b11, 1, 0, 0, 1);
    check("eq_cond_ex", {31'b0, cond_ex}, 32'd0);
    check("eq_reg_write", {31'b0, reg_write}, 32'd0);
    check("eq_flags", {28'b0, flags}, 32'h0);
    check("eq_cnt", {{(32-CNT_W){1'b0}}, squash_cnt}, 32'd1);

    // Back-to-back dependency through the flags register.
    step(1, 4'hE, 4'b0110, 2'b11, 0, 0, 0, 1);
    check("al_flags", {28'b0, flags}, 32'h6);
    step(1, 4'h0, 4'b0000, 2'b00, 0, 1, 0, 1);
    check("dep_mem_write", {31'b0, mem_write}, 32'd1);
    check("dep_cond_ex", {31'b0, cond_ex}, 32'd1);

    // Partial flag update: only N,Z written.
    step(1, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 1);
    step(1, 4'hE, 4'b0110, 2'b10, 0, 0, 0, 1);
    check("partial_flags", {28'b0, flags}, 32'h5);
    step(1, 4'hC, 4'b0000, 2'b00, 1, 0, 0, 1);
    check("gt_cond_ex", {31'b0, cond_ex}, 32'd0);

    // Sweep every condition over every flag value.
    for (int f = 0; f < 16; f++) begin
      step(1, 4'hE, f[3:0], 2'b11, 0, 0, 0, 1);
      for (int c = 0; c < 16; c++)
        step(1, c[3:0], 4'b0000, 2'b00, 1, 1, 1, 1);
    end

    // Backpressure: three stalled cycles must not accept or update anything.
    step(1, 4'hE, 4'b0000, 2'b11, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_flags", {28'b0, flags}, 32'h0);
    end
    for (int i = 0; i < 4; i++)
      step(1, 4'h1, 4'b1010, 2'b11, 1, 0, 1, 1);
    step(0, 4'h0, 4'b0000, 2'b00, 0, 0, 0, 1);
    check("drain_empty", sb.size(), 32'd0);

    // Reset while an instruction is stalled in the output register.
    step(1, 4'hE, 4'b0000, 2'b00, 1, 1, 1, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Saturate the squash counter (flags are zero, so EQ always fails).
    for (int i = 0; i < 15; i++)
      step(1, 4'h0, 4'b0000, 2'b00, 1, 1, 1, 1);
    check("sat_at_max", {{(32-CNT_W){1'b0}}, squash_cnt}, 32'd15);
    step(1, 4'h0, 4'b0000, 2'b00, 1, 1, 1, 1);
    check("sat_hold", {{(32-CNT_W){1'b0}}, squash_cnt}, 32'd15);
    step(0, 4'h0, 4'b0000, 2'b00, 0, 0, 0, 1);
    check("final_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
